// File: rtl/rob_core.sv
// Reorder buffer: in-order dual enqueue from dispatch, dual writeback completion, in-order dual retire.
// Latency: an entry can retire two cycles after its enqueue edge (enqueue edge, writeback edge, then commit visible).
// Backpressure: dispatch watches counter; requests that do not fit are dropped, and flush overrides everything.
module rob_core #(
  parameter int ROB_SIZE     = 64,
  parameter int ROB_SIZE_LOG = 6,
  parameter int PC_W         = 64,
  parameter int LREG_W       = 5,
  parameter int PREG_W       = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enq0_valid,
  input  logic [PC_W-1:0]         enq0_pc,
  input  logic [LREG_W-1:0]       enq0_lrd,
  input  logic [PREG_W-1:0]       enq0_prd,
  input  logic [PREG_W-1:0]       enq0_old_prd,
  input  logic                    enq0_need_to_wb,
  input  logic                    enq1_valid,
  input  logic [PC_W-1:0]         enq1_pc,
  input  logic [LREG_W-1:0]       enq1_lrd,
  input  logic [PREG_W-1:0]       enq1_prd,
  input  logic [PREG_W-1:0]       enq1_old_prd,
  input  logic                    enq1_need_to_wb,
  output logic [ROB_SIZE_LOG:0]   counter,
  output logic                    enq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] enq_robidx,
  input  logic                    wb0_valid,
  input  logic [ROB_SIZE_LOG-1:0] wb0_robidx,
  input  logic                    wb1_valid,
  input  logic [ROB_SIZE_LOG-1:0] wb1_robidx,
  output logic                    commit0_valid,
  output logic [PC_W-1:0]         commit0_pc,
  output logic [LREG_W-1:0]       commit0_lrd,
  output logic [PREG_W-1:0]       commit0_prd,
  output logic [PREG_W-1:0]       commit0_old_prd,
  output logic                    commit0_need_to_wb,
  output logic                    commit1_valid,
  output logic [PC_W-1:0]         commit1_pc,
  output logic [LREG_W-1:0]       commit1_lrd,
  output logic [PREG_W-1:0]       commit1_prd,
  output logic [PREG_W-1:0]       commit1_old_prd,
  output logic                    commit1_need_to_wb,
  input  logic                    flush_valid
);

  // Pointers are {wrap flag, index}; a plain binary add wraps the index and toggles the flag.
  localparam int PW = ROB_SIZE_LOG + 1;
  localparam logic [PW-1:0] SIZE_C = PW'(ROB_SIZE);

  typedef logic [ROB_SIZE_LOG-1:0] idx_t;
  typedef logic [PW-1:0]           ptr_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [LREG_W-1:0] lrd;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
    logic              need_to_wb;
  } entry_t;

  entry_t              payload [ROB_SIZE];
  logic [ROB_SIZE-1:0] ent_vld;
  logic [ROB_SIZE-1:0] ent_cmp;
  ptr_t                head_ptr;
  ptr_t                tail_ptr;
  ptr_t                count_q;

  idx_t   head_idx, head1_idx, tail_idx, tail1_idx;
  logic   enq0_acc, enq1_acc, com0, com1;
  ptr_t   n_enq, n_com;
  entry_t enq0_ent, enq1_ent, head_ent, head1_ent;

  assign head_idx  = head_ptr[ROB_SIZE_LOG-1:0];
  assign head1_idx = head_idx + idx_t'(1);
  assign tail_idx  = tail_ptr[ROB_SIZE_LOG-1:0];
  assign tail1_idx = tail_idx + idx_t'(1);

  // Admission is judged on the pre-edge occupancy, so a full ROB refuses even while retiring.
  assign enq0_acc = enq0_valid && !flush_valid && (count_q < SIZE_C);
  assign enq1_acc = enq1_valid && enq0_acc && ((count_q + ptr_t'(1)) < SIZE_C);
  assign n_enq    = ptr_t'(enq0_acc) + ptr_t'(enq1_acc);

  // Retire only from the head, strictly in order; flush suppresses retirement.
  assign com0  = !flush_valid && ent_vld[head_idx] && ent_cmp[head_idx];
  assign com1  = com0 && ent_vld[head1_idx] && ent_cmp[head1_idx];
  assign n_com = ptr_t'(com0) + ptr_t'(com1);

  assign enq0_ent = '{pc: enq0_pc, lrd: enq0_lrd, prd: enq0_prd,
                      old_prd: enq0_old_prd, need_to_wb: enq0_need_to_wb};
  assign enq1_ent = '{pc: enq1_pc, lrd: enq1_lrd, prd: enq1_prd,
                      old_prd: enq1_old_prd, need_to_wb: enq1_need_to_wb};

  assign head_ent  = payload[head_idx];
  assign head1_ent = payload[head1_idx];

  assign counter         = count_q;
  assign enq_robidx_flag = tail_ptr[ROB_SIZE_LOG];
  assign enq_robidx      = tail_idx;

  assign commit0_valid      = com0;
  assign commit0_pc         = com0 ? head_ent.pc         : '0;
  assign commit0_lrd        = com0 ? head_ent.lrd        : '0;
  assign commit0_prd        = com0 ? head_ent.prd        : '0;
  assign commit0_old_prd    = com0 ? head_ent.old_prd    : '0;
  assign commit0_need_to_wb = com0 ? head_ent.need_to_wb : 1'b0;
  assign commit1_valid      = com1;
  assign commit1_pc         = com1 ? head1_ent.pc         : '0;
  assign commit1_lrd        = com1 ? head1_ent.lrd        : '0;
  assign commit1_prd        = com1 ? head1_ent.prd        : '0;
  assign commit1_old_prd    = com1 ? head1_ent.old_prd    : '0;
  assign commit1_need_to_wb = com1 ? head1_ent.need_to_wb : 1'b0;

  // Payload capture; contents are only observed through valid-gated outputs, so no reset is needed.
  always_ff @(posedge clock) begin
    if (enq0_acc) payload[tail_idx]  <= enq0_ent;
    if (enq1_acc) payload[tail1_idx] <= enq1_ent;
  end

  // Entry status, pointers and occupancy; later assignments win (wb, then retire, then enqueue).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld  <= '0;
      ent_cmp  <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (flush_valid) begin
      ent_vld  <= '0;
      ent_cmp  <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (wb0_valid && ent_vld[wb0_robidx]) ent_cmp[wb0_robidx] <= 1'b1;
      if (wb1_valid && ent_vld[wb1_robidx]) ent_cmp[wb1_robidx] <= 1'b1;
      if (com0) begin
        ent_vld[head_idx] <= 1'b0;
        ent_cmp[head_idx] <= 1'b0;
      end
      if (com1) begin
        ent_vld[head1_idx] <= 1'b0;
        ent_cmp[head1_idx] <= 1'b0;
      end
      if (enq0_acc) begin
        ent_vld[tail_idx] <= 1'b1;
        ent_cmp[tail_idx] <= 1'b0;
      end
      if (enq1_acc) begin
        ent_vld[tail1_idx] <= 1'b1;
        ent_cmp[tail1_idx] <= 1'b0;
      end
      head_ptr <= head_ptr + n_com;
      tail_ptr <= tail_ptr + n_enq;
      count_q  <= count_q + n_enq - n_com;
    end
  end

endmodule

// File: tb/tb_rob_core.sv
// Directed bench for a 4-entry rob_core: one vector per clock cycle, inputs and expected pre-edge outputs.
// Latency: outputs are checked 1ns after the falling edge on which the vector's inputs are driven.
// Backpressure: overflow, full-while-retiring and flush cases are in the vector table.
module tb_rob_core;

  localparam int RS  = 4;
  localparam int RSL = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq0_valid = 1'b0, enq1_valid = 1'b0;
  logic [63:0] enq0_pc = '0, enq1_pc = '0;
  logic [4:0]  enq0_lrd = '0, enq1_lrd = '0;
  logic [5:0]  enq0_prd = '0, enq1_prd = '0, enq0_old_prd = '0, enq1_old_prd = '0;
  logic        enq0_need_to_wb = 1'b0, enq1_need_to_wb = 1'b0;
  logic [2:0]  counter;
  logic        enq_robidx_flag;
  logic [1:0]  enq_robidx;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [1:0]  wb0_robidx = '0, wb1_robidx = '0;
  logic        commit0_valid, commit1_valid;
  logic [63:0] commit0_pc, commit1_pc;
  logic [4:0]  commit0_lrd, commit1_lrd;
  logic [5:0]  commit0_prd, commit1_prd, commit0_old_prd, commit1_old_prd;
  logic        commit0_need_to_wb, commit1_need_to_wb;
  logic        flush_valid = 1'b0;

  rob_core #(.ROB_SIZE(RS), .ROB_SIZE_LOG(RSL), .PC_W(64), .LREG_W(5), .PREG_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq0_valid(enq0_valid), .enq0_pc(enq0_pc), .enq0_lrd(enq0_lrd), .enq0_prd(enq0_prd),
    .enq0_old_prd(enq0_old_prd), .enq0_need_to_wb(enq0_need_to_wb),
    .enq1_valid(enq1_valid), .enq1_pc(enq1_pc), .enq1_lrd(enq1_lrd), .enq1_prd(enq1_prd),
    .enq1_old_prd(enq1_old_prd), .enq1_need_to_wb(enq1_need_to_wb),
    .counter(counter), .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .wb0_valid(wb0_valid), .wb0_robidx(wb0_robidx), .wb1_valid(wb1_valid), .wb1_robidx(wb1_robidx),
    .commit0_valid(commit0_valid), .commit0_pc(commit0_pc), .commit0_lrd(commit0_lrd),
    .commit0_prd(commit0_prd), .commit0_old_prd(commit0_old_prd), .commit0_need_to_wb(commit0_need_to_wb),
    .commit1_valid(commit1_valid), .commit1_pc(commit1_pc), .commit1_lrd(commit1_lrd),
    .commit1_prd(commit1_prd), .commit1_old_prd(commit1_old_prd), .commit1_need_to_wb(commit1_need_to_wb),
    .flush_valid(flush_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst, flush, e0v, e1v, w0v, w1v;
    logic [63:0] e0pc, e1pc;
    logic [1:0]  w0i, w1i;
    logic [2:0]  cnt;
    bit          flag;
    logic [1:0]  idx;
    bit          c0, c1;
    logic [63:0] c0pc, c1pc;
  } vec_t;

  vec_t vq[$];
  int   napplied = 0;
  int   nfail = 0;

  // Side fields are derived from the pc so each committed entry is self-identifying.
  function automatic logic [4:0] lrd_of(input logic [63:0] pc); return pc[6:2]; endfunction
  function automatic logic [5:0] prd_of(input logic [63:0] pc); return pc[7:2]; endfunction
  function automatic logic [5:0] old_of(input logic [63:0] pc); return pc[9:4]; endfunction
  function automatic logic       nwb_of(input logic [63:0] pc); return pc[2];   endfunction

  task automatic add(input int rst, input int flush, input int e0v, input int e0pc,
                     input int e1v, input int e1pc, input int w0v, input int w0i,
                     input int w1v, input int w1i, input int cnt, input int flag, input int idx,
                     input int c0, input int c0pc, input int c1, input int c1pc);
    vec_t v;
    v.rst = (rst != 0);  v.flush = (flush != 0);
    v.e0v = (e0v != 0);  v.e0pc = 64'(e0pc);
    v.e1v = (e1v != 0);  v.e1pc = 64'(e1pc);
    v.w0v = (w0v != 0);  v.w0i = 2'(w0i);
    v.w1v = (w1v != 0);  v.w1i = 2'(w1i);
    v.cnt = 3'(cnt);     v.flag = (flag != 0);  v.idx = 2'(idx);
    v.c0 = (c0 != 0);    v.c0pc = 64'(c0pc);
    v.c1 = (c1 != 0);    v.c1pc = 64'(c1pc);
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset_n = !v.rst;  flush_valid = v.flush;
    enq0_valid = v.e0v;  enq0_pc = v.e0pc;  enq0_lrd = lrd_of(v.e0pc);  enq0_prd = prd_of(v.e0pc);
    enq0_old_prd = old_of(v.e0pc);  enq0_need_to_wb = nwb_of(v.e0pc);
    enq1_valid = v.e1v;  enq1_pc = v.e1pc;  enq1_lrd = lrd_of(v.e1pc);  enq1_prd = prd_of(v.e1pc);
    enq1_old_prd = old_of(v.e1pc);  enq1_need_to_wb = nwb_of(v.e1pc);
    wb0_valid = v.w0v;  wb0_robidx = v.w0i;  wb1_valid = v.w1v;  wb1_robidx = v.w1i;
  endtask

  task automatic check(input vec_t v, input string name);
    logic [63:0] x0pc, x1pc;
    bit          fields_ok;
    x0pc = v.c0 ? v.c0pc : 64'h0;
    x1pc = v.c1 ? v.c1pc : 64'h0;
    fields_ok = (commit0_lrd == (v.c0 ? lrd_of(x0pc) : 5'h0)) && (commit0_prd == (v.c0 ? prd_of(x0pc) : 6'h0)) &&
                (commit0_old_prd == (v.c0 ? old_of(x0pc) : 6'h0)) && (commit0_need_to_wb == (v.c0 && nwb_of(x0pc))) &&
                (commit1_lrd == (v.c1 ? lrd_of(x1pc) : 5'h0)) && (commit1_prd == (v.c1 ? prd_of(x1pc) : 6'h0)) &&
                (commit1_old_prd == (v.c1 ? old_of(x1pc) : 6'h0)) && (commit1_need_to_wb == (v.c1 && nwb_of(x1pc)));
    napplied++;
    if (counter !== v.cnt || enq_robidx_flag !== v.flag || enq_robidx !== v.idx ||
        commit0_valid !== v.c0 || commit1_valid !== v.c1 ||
        commit0_pc !== x0pc || commit1_pc !== x1pc || !fields_ok) begin
      nfail++;
      $display("FAIL %s: cnt %0d want %0d, flag %0d want %0d, idx %0d want %0d, c0 %0d want %0d pc %h want %h, c1 %0d want %0d pc %h want %h, side fields ok %0d want 1",
               name, counter, v.cnt, enq_robidx_flag, v.flag, enq_robidx, v.idx,
               commit0_valid, v.c0, commit0_pc, x0pc, commit1_valid, v.c1, commit1_pc, x1pc, fields_ok);
    end
  endtask

  initial begin
    vec_t idle_v;
    int   lat;
    //   rst fl e0v e0pc   e1v e1pc   w0v w0i w1v w1i cnt flg idx c0 c0pc   c1 c1pc
    add(1, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // reset state
    add(0, 0, 1, 'h100,  1, 'h104,  0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // dual enqueue
    add(0, 0, 0, 0,      0, 0,      1, 1, 0, 0,  2, 0, 2,  0, 0,      0, 0);      // wb idx1 only
    add(0, 0, 0, 0,      0, 0,      1, 0, 0, 0,  2, 0, 2,  0, 0,      0, 0);      // wb idx0
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  2, 0, 2,  1, 'h100,  1, 'h104);  // dual commit
    add(0, 0, 1, 'h180,  0, 0,      0, 0, 0, 0,  0, 0, 2,  0, 0,      0, 0);      // leave one pending
    add(1, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // mid-stream reset
    add(0, 0, 1, 'h200,  1, 'h204,  0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // fill
    add(0, 0, 1, 'h208,  1, 'h20c,  0, 0, 0, 0,  2, 0, 2,  0, 0,      0, 0);
    add(0, 0, 1, 'h210,  0, 0,      0, 0, 0, 0,  4, 1, 0,  0, 0,      0, 0);      // fifth enq dropped
    add(0, 0, 0, 0,      0, 0,      1, 0, 0, 0,  4, 1, 0,  0, 0,      0, 0);      // still full, wb head
    add(0, 0, 1, 'h214,  0, 0,      0, 0, 0, 0,  4, 1, 0,  1, 'h200,  0, 0);      // enq vs commit when full
    add(0, 0, 1, 'h214,  0, 0,      0, 0, 0, 0,  3, 1, 0,  0, 0,      0, 0);      // re-enqueue at idx0
    add(0, 0, 0, 0,      0, 0,      1, 1, 1, 2,  4, 1, 1,  0, 0,      0, 0);
    add(0, 0, 0, 0,      0, 0,      1, 3, 1, 0,  4, 1, 1,  1, 'h204,  1, 'h208);
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  2, 1, 1,  1, 'h20c,  1, 'h214);  // commit across wrap
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 1, 1,  0, 0,      0, 0);
    add(1, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);
    add(0, 0, 1, 'h300,  0, 0,      0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // wrap stream
    add(0, 0, 1, 'h304,  0, 0,      1, 0, 0, 0,  1, 0, 1,  0, 0,      0, 0);
    add(0, 0, 1, 'h308,  0, 0,      1, 1, 0, 0,  2, 0, 2,  1, 'h300,  0, 0);
    add(0, 0, 1, 'h30c,  0, 0,      1, 2, 0, 0,  2, 0, 3,  1, 'h304,  0, 0);
    add(0, 0, 1, 'h310,  0, 0,      1, 3, 0, 0,  2, 1, 0,  1, 'h308,  0, 0);
    add(0, 0, 1, 'h314,  0, 0,      1, 0, 0, 0,  2, 1, 1,  1, 'h30c,  0, 0);
    add(0, 0, 0, 0,      0, 0,      1, 1, 0, 0,  2, 1, 2,  1, 'h310,  0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  1, 1, 2,  1, 'h314,  0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 1, 2,  0, 0,      0, 0);
    add(0, 0, 1, 'h400,  1, 'h404,  0, 0, 0, 0,  0, 1, 2,  0, 0,      0, 0);      // three entries
    add(0, 0, 1, 'h408,  0, 0,      0, 0, 0, 0,  2, 0, 0,  0, 0,      0, 0);
    add(0, 0, 0, 0,      0, 0,      1, 2, 0, 0,  3, 0, 1,  0, 0,      0, 0);      // complete head
    add(0, 1, 1, 'h40c,  0, 0,      1, 3, 0, 0,  3, 0, 1,  0, 0,      0, 0);      // flush masks commit
    add(0, 0, 1, 'h500,  0, 0,      0, 0, 0, 0,  0, 0, 0,  0, 0,      0, 0);      // lands at idx0
    add(0, 0, 0, 0,      0, 0,      1, 0, 1, 0,  1, 0, 1,  0, 0,      0, 0);      // both wb same idx
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  1, 0, 1,  1, 'h500,  0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0, 0, 0,  0, 0, 1,  0, 0,      0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      drive(vq[i]);
      #1;
      check(vq[i], $sformatf("vec%0d", i));
    end

    // Enqueue-to-commit latency: enqueue, writeback next cycle, commit must be visible right after.
    idle_v = '{default: 0};
    @(negedge clock);
    idle_v.e0v = 1'b1;  idle_v.e0pc = 64'h700;
    drive(idle_v);
    @(negedge clock);
    idle_v = '{default: 0};
    idle_v.w0v = 1'b1;  idle_v.w0i = 2'd1;
    drive(idle_v);
    @(negedge clock);
    idle_v = '{default: 0};
    drive(idle_v);
    lat = -1;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      #1;
      if (commit0_valid) lat = k;
      else @(negedge clock);
    end
    napplied++;
    if (lat != 0 || commit0_pc !== 64'h700) begin
      nfail++;
      $display("FAIL latency: commit seen after %0d extra cycles (-1 = never) pc %h, want 0 extra cycles pc 0000000000000700",
               lat, commit0_pc);
    end
    @(negedge clock);
    idle_v.cnt = 3'd0;  idle_v.idx = 2'd2;
    #1;
    check(idle_v, "latency_drain");

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
- Reorder buffer that answers the dispatch stage's enqueue requests.
- Supplies `counter`, `enq_robidx_flag` and `enq_robidx` to dispatch and accepts up to two in-order enqueues per cycle.
- Marks entries complete from two writeback ports.
- Retires up to two completed head entries per cycle toward rename/freelist; a flush empties the buffer.

Parameters:
- ROB_SIZE, 64, number of entries (power of two, >=4)
- ROB_SIZE_LOG, 6, log2(ROB_SIZE)
- PC_W, 64, PC width
- LREG_W, 5, logical register index width
- PREG_W, 6, physical register index width

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enq0_valid  in  1  dispatch slot0 enqueue
- enq0_pc  in  PC_W  slot0 pc
- enq0_lrd  in  LREG_W  slot0 logical dest
- enq0_prd  in  PREG_W  slot0 physical dest
- enq0_old_prd  in  PREG_W  slot0 previous mapping of lrd
- enq0_need_to_wb  in  1  slot0 writes a register
- enq1_valid, enq1_pc, enq1_lrd, enq1_prd, enq1_old_prd, enq1_need_to_wb  in  as slot0  slot1 (older = slot0)
- counter  out  ROB_SIZE_LOG+1  occupied entries, 0..ROB_SIZE
- enq_robidx_flag  out  1  tail wrap flag
- enq_robidx  out  ROB_SIZE_LOG  tail index (slot0 target; slot1 target = tail+1)
- wb0_valid  in  1  writeback completion
- wb0_robidx  in  ROB_SIZE_LOG  completing entry
- wb1_valid, wb1_robidx  in  as wb0  second writeback port
- commit0_valid  out  1  head entry retires this cycle
- commit0_pc / commit0_lrd / commit0_prd / commit0_old_prd / commit0_need_to_wb  out  as enq  head entry fields
- commit1_valid + same field set  out  head+1 entry retires
- flush_valid  in  1  discard all entries

Behaviour:
- Reset (async, reset_n=0):
  - head and tail index and flag = 0; all entry valid and complete bits = 0; counter = 0.
  - commit*_valid = 0; commit* fields = 0.
- Pointers:
  - head/tail are {flag, idx}; idx wraps ROB_SIZE-1 -> 0 and flag toggles on wrap.
  - Empty: flags equal and idx equal. Full: flags differ and idx equal.
- Enqueue, per cycle in slot order:
  - enq0 is accepted if enq0_valid and counter < ROB_SIZE.
  - enq1 is accepted if enq1_valid, enq0 accepted, and counter+1 < ROB_SIZE.
  - enq1_valid without enq0_valid is ignored.
  - An accepted slot writes entry tail+k with valid=1 and complete=0.
  - Tail advances by the accepted count at the clock edge.
  - Non-accepted requests are dropped with no state change. Dispatch guarantees this never happens in normal operation; the bench must assert it.
- Writeback:
  - wbN_valid sets complete=1 on entry wbN_robidx if that entry is valid; otherwise ignored.
  - Both ports naming the same index is legal.
  - Completion is visible to commit the next cycle.
- Commit (combinational from registered state):
  - commit0_valid = head entry valid & complete.
  - commit1_valid = commit0_valid & entry(head+1) valid & complete.
  - Fields show head / head+1 contents and are 0 when the matching valid is 0.
  - Retired entries clear valid and complete at the edge; head advances by the commit count (0..2).
- Counter update: counter_next = counter + enq_accepted - committed. Simultaneous enqueue and commit when full is legal: enqueue is judged on the pre-edge counter, so a full ROB rejects enqueue even while committing.
- Flush (flush_valid=1):
  - Overrides enqueue, writeback and commit in the same cycle.
  - commit*_valid is forced to 0 combinationally.
  - At the edge: all valid/complete = 0, head = tail = 0 (both flags 0), counter = 0.
  - Enqueue is accepted again the following cycle.
- Latency: enqueue-to-earliest-commit is 2 cycles (enqueue edge, writeback edge, commit visible the cycle after).
- Reset deasserting mid-stream: the first edge after release behaves as an empty ROB.

Test Plan:
- ROB_SIZE=4. Reset -> counter=0, enq_robidx=0, flag=0, commit0_valid=0.
- Enqueue pc 0x100 then 0x104 in one cycle -> counter=2, enq_robidx=2. Writeback robidx 1 only -> no commit. Writeback robidx 0 -> next cycle commit0_valid=1 and commit1_valid=1 (pc 0x100 and 0x104) -> then counter=0.
- Fill 4 entries -> counter=4, flag=1, idx=0. Fifth enqueue -> dropped, counter stays 4.
- Full ROB: writeback head, then present enq0 in the same cycle as commit0 -> enq rejected, counter=3 after the edge. Re-enqueue -> accepted at idx 0 with flag 1.
- Wrap: enqueue and commit 6 single entries -> enq_robidx sequence 0,1,2,3,0,1 with flag toggling at 3->0; commit order matches pc order.
- With 3 entries, 1 completed, assert flush together with enq0 and wb -> commit0_valid=0 that cycle; next cycle counter=0, head=tail=0, and a new enqueue lands at idx 0.
